rr_stream_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered stream multiplexer. Successor to the 32-bit 2:1 combinational mux.
- Replaces the external select with valid/ready inputs and on-chip arbitration: round-robin or fixed priority.
- Output is registered and drives one downstream consumer.
- Used wherever several producers share one 32-bit datapath.

---
 rtl/rr_stream_mux.sv | 93 +++++++++
 tb/tb_rr_stream_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel registered stream mux with round-robin or fixed-priority arbitration.
// Optional packet lock (grant held until in_last) is enabled by defining RR_STREAM_MUX_PKT_LOCK_EN.
module rr_stream_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N-1:0]       in_last,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_sel
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SELW-1:0]  r_sel;
    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  w_grant;
    logic [SELW-1:0]  w_idx;
    logic [SELW-1:0]  w_next_ptr;
    logic             w_any;
    logic             w_load;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    logic             r_lock;
    logic [SELW-1:0]  r_lock_ch;
`else
    logic             w_unused_last;
    assign w_unused_last = ^in_last;
`endif

    assign w_load     = !r_valid || out_ready;
    assign w_next_ptr = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;
    assign in_ready   = (rst_n && w_load && w_any) ? N'(1) << w_grant : '0;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_sel    = r_sel;

    // Scan from the far end so the lowest offset (highest precedence) is written last.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = mode ? SELW'(k) : SELW'((int'(r_ptr) + k) % N);
            if (in_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        if (r_lock) begin
            w_any   = in_valid[r_lock_ch];
            w_grant = r_lock_ch;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sel     <= '0;
            r_ptr     <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
`endif
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= in_data[int'(w_grant)*WIDTH +: WIDTH];
                r_sel  <= w_grant;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
                if (in_last[w_grant]) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_next_ptr;
                end else begin
                    r_lock    <= 1'b1;
                    r_lock_ch <= w_grant;
                end
`else
                r_ptr <= w_next_ptr;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: randomized and directed checks of rr_stream_mux against a behavioural model.
module tb_rr_stream_mux;
    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mode = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0] in_valid = '0;
    logic [N-1:0] in_last = '0;
    logic [N-1:0] in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_sel;

    int checks = 0;
    int errors = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel, m_ptr, m_lch;
    logic         m_lock;

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 1'b0; m_lch = 0;
    endtask

    // Channel the rules award this cycle, or -1 when nothing is eligible.
    function automatic int pick();
        if (m_lock) return in_valid[m_lch] ? m_lch : -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = mode ? k : (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = pick();
        if (!rst_n || (m_valid && !out_ready) || g < 0) return '0;
        return 4'b0001 << g;
    endfunction

    task automatic set_data(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    // Compare DUT to model, advance both one clock, return at the next falling edge.
    task automatic step();
        int g;
        logic load;
        #1;
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_sel", out_sel, m_sel);
        @(posedge clk);
        g = pick();
        load = !m_valid || out_ready;
        if (load) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_data = in_data[g*W +: W];
                m_sel = g;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
                if (in_last[g]) begin
                    m_lock = 1'b0;
                    m_ptr = (g + 1) % N;
                end else begin
                    m_lock = 1'b1;
                    m_lch = g;
                end
`else
                m_ptr = (g + 1) % N;
`endif
            end
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid = 4'b1111;
        #1 rst_n = 1'b0;
        mreset();
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_sel", out_sel, 2'd0);
        chk("rst_ready", in_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, 32'hA0 + i);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_sel", out_sel, 64'(i % 4));
            chk("rr_data", out_data, 64'(32'hA0 + i % 4));
        end
        mode = 1'b1;
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prio_sel", out_sel, 2'd1);
        end
        in_valid = 4'b1000;
        step();
        chk("prio_drop_sel", out_sel, 2'd3);
        in_valid = 4'b0001;
        set_data(0, 32'h5);
        step();
        chk("bp_load", out_data, 32'h5);
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", out_data, 32'h5);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        in_valid = 4'b0001;
        set_data(0, 32'h6);
        #1 chk("bp_release_ready", in_ready, 4'b0001);
        step();
        chk("bp_next", out_data, 32'h6);
        mode = 1'b0;
        in_valid = 4'b0100;
        set_data(2, 32'h77);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_sel", out_sel, 2'd2);
            chk("single_valid", out_valid, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 4'b0000);
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        mode = 1'b0;
        in_valid = 4'b0011;
        in_last = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_last = (i == 2) ? 4'b0001 : 4'b0000;
            step();
            chk("lock_sel", out_sel, (i < 3) ? 2'd0 : 2'd1);
        end
        in_last = 4'b0000;
`endif
        for (int i = 0; i < 500; i++) begin
            mode = 1'($urandom);
            in_valid = 4'($urandom);
            in_last = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            for (int c = 0; c < N; c++) set_data(c, $urandom);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
